fsm_level_sel: RTL and testbench

Parametrised level-select state machine for the LED/FND/motor front panel, generalising the fixed 5-button light-state selector. It picks one of LEVELS levels from synchronised, edge-detected direct-select buttons, up/down step buttons, or a timed auto-cycle mode. It drives a binary level, a one-hot level and a change strobe to the LED, FND and motor drivers.

---
 rtl/fsm_level_sel.sv | 157 +++++++++++++++
 tb/tb_fsm_level_sel.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_level_sel.sv
// Front-panel level selector: direct, up/down or timed auto-cycle pick of one of LEVELS levels.
// Latency: button/up/down act SYNC_STAGES edges after first sample; auto mode one edge sooner.
// Backpressure: none; inputs are sampled levels and every output is registered each cycle.
module fsm_level_sel #(
    parameter int LEVELS      = 5,
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_PERIOD = 100_000_000,
    parameter int WRAP        = 1,
    localparam int LW         = (LEVELS > 2) ? $clog2(LEVELS) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [LEVELS-1:0] i_button,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_auto,
    output logic [LW-1:0]     o_level,
    output logic [LEVELS-1:0] o_level_onehot,
    output logic              o_changed,
    output logic              o_auto_active
);
    localparam int CW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } mode_t;

    logic [LEVELS-1:0] r_btn_sync [SYNC_STAGES];
    logic              r_up_sync   [SYNC_STAGES];
    logic              r_down_sync [SYNC_STAGES];
    logic              r_auto_sync [SYNC_STAGES-1];
    logic [LEVELS-1:0] r_btn_prev;
    logic              r_up_prev;
    logic              r_down_prev;

    mode_t             r_mode;
    logic [CW-1:0]     r_cnt;
    logic [LW-1:0]     r_level;
    logic [LEVELS-1:0] r_onehot;
    logic              r_changed;

    logic [LEVELS-1:0] w_btn_evt;
    logic              w_up_evt;
    logic              w_down_evt;
    logic              w_any_evt;
    mode_t             w_mode_nxt;
    logic              w_tick;
    logic              w_at_top;
    logic              w_at_bot;
    logic              w_illegal;
    logic [LW-1:0]     w_sel;
    logic [LW-1:0]     w_level_nxt;

    // r_mode acts as the final flop of the i_auto synchroniser, so the chain here is one shorter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_btn_sync[s]  <= '0;
                r_up_sync[s]   <= 1'b0;
                r_down_sync[s] <= 1'b0;
            end
            for (int s = 0; s < SYNC_STAGES-1; s++) begin
                r_auto_sync[s] <= 1'b0;
            end
            r_btn_prev  <= '0;
            r_up_prev   <= 1'b0;
            r_down_prev <= 1'b0;
        end else begin
            r_btn_sync[0]  <= i_button;
            r_up_sync[0]   <= i_up;
            r_down_sync[0] <= i_down;
            r_auto_sync[0] <= i_auto;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_btn_sync[s]  <= r_btn_sync[s-1];
                r_up_sync[s]   <= r_up_sync[s-1];
                r_down_sync[s] <= r_down_sync[s-1];
            end
            for (int s = 1; s < SYNC_STAGES-1; s++) begin
                r_auto_sync[s] <= r_auto_sync[s-1];
            end
            r_btn_prev  <= r_btn_sync[SYNC_STAGES-1];
            r_up_prev   <= r_up_sync[SYNC_STAGES-1];
            r_down_prev <= r_down_sync[SYNC_STAGES-1];
        end
    end

    assign w_btn_evt  = r_btn_sync[SYNC_STAGES-1] & ~r_btn_prev;
    assign w_up_evt   = r_up_sync[SYNC_STAGES-1] & ~r_up_prev;
    assign w_down_evt = r_down_sync[SYNC_STAGES-1] & ~r_down_prev;
    assign w_any_evt  = (|w_btn_evt) | w_up_evt | w_down_evt;
    assign w_mode_nxt = r_auto_sync[SYNC_STAGES-2] ? S_AUTO : S_MANUAL;
    assign w_tick     = (r_mode == S_AUTO) && (r_cnt == CW'(AUTO_PERIOD-1));
    assign w_at_top   = (r_level == LW'(LEVELS-1));
    assign w_at_bot   = (r_level == '0);

    generate
        if ((1 << LW) != LEVELS) begin : g_illegal
            assign w_illegal = (r_level > LW'(LEVELS-1));
        end else begin : g_no_illegal
            assign w_illegal = 1'b0;
        end
    endgenerate

    always_comb begin
        w_sel = '0;
        for (int k = LEVELS-1; k >= 0; k--) begin
            if (w_btn_evt[k]) w_sel = LW'(k);
        end
    end

    // Priority: illegal recovery, direct select, single step (up+down cancel), auto tick.
    always_comb begin
        w_level_nxt = r_level;
        if (w_illegal) begin
            w_level_nxt = '0;
        end else if (|w_btn_evt) begin
            w_level_nxt = w_sel;
        end else if (w_up_evt ^ w_down_evt) begin
            if (w_up_evt) begin
                if (w_at_top) w_level_nxt = (WRAP != 0) ? '0 : r_level;
                else          w_level_nxt = r_level + 1'b1;
            end else begin
                if (w_at_bot) w_level_nxt = (WRAP != 0) ? LW'(LEVELS-1) : r_level;
                else          w_level_nxt = r_level - 1'b1;
            end
        end else if (w_tick) begin
            w_level_nxt = w_at_top ? '0 : r_level + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mode    <= S_MANUAL;
            r_cnt     <= '0;
            r_level   <= '0;
            r_onehot  <= LEVELS'(1);
            r_changed <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            if ((w_mode_nxt != r_mode) || (r_mode == S_MANUAL) || w_any_evt || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level   <= w_level_nxt;
            r_onehot  <= LEVELS'(1) << w_level_nxt;
            r_changed <= (w_level_nxt != r_level);
        end
    end

    assign o_level        = r_level;
    assign o_level_onehot = r_onehot;
    assign o_changed      = r_changed;
    assign o_auto_active  = (r_mode == S_AUTO);

endmodule

// File: tb/tb_fsm_level_sel.sv
// Bench for fsm_level_sel: four parameter sets share one stimulus stream, each with its own timing model.
module tb_fsm_level_sel;
    localparam int SS = 2;
    localparam int AP = 8;
    localparam int HN = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] m_btn = '0;
    logic        m_up  = 1'b0;
    logic        m_down = 1'b0;
    logic        m_auto = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int LV = (g == 2) ? 2 : ((g == 3) ? 16 : 5);
        localparam int WR = (g == 1) ? 0 : 1;
        localparam int LW = (LV > 2) ? $clog2(LV) : 1;

        logic [LV-1:0] w_btn;
        logic [LW-1:0] w_lvl;
        logic [LV-1:0] w_oh;
        logic          w_chg;
        logic          w_act;

        assign w_btn = m_btn[LV-1:0];

        fsm_level_sel #(
            .LEVELS      (LV),
            .SYNC_STAGES (SS),
            .AUTO_PERIOD (AP),
            .WRAP        (WR)
        ) u_dut (
            .i_clk          (clk),
            .i_reset_n      (rst_n),
            .i_button       (w_btn),
            .i_up           (m_up),
            .i_down         (m_down),
            .i_auto         (m_auto),
            .o_level        (w_lvl),
            .o_level_onehot (w_oh),
            .o_changed      (w_chg),
            .o_auto_active  (w_act)
        );

        // Reference: history of input samples per edge; samples taken before the last reset read as 0.
        int          n      = 0;
        int          base   = 0;
        int          r_last = 0;
        int          m_lvl  = 0;
        logic        m_chg  = 1'b0;
        logic        m_mode = 1'b0;
        logic [15:0] hb [HN];
        logic        hu [HN];
        logic        hd [HN];
        logic        ha [HN];

        function automatic logic [15:0] smp_b(input int idx);
            if (idx < base) return '0;
            return hb[idx % HN];
        endfunction
        function automatic logic smp_u(input int idx);
            if (idx < base) return 1'b0;
            return hu[idx % HN];
        endfunction
        function automatic logic smp_d(input int idx);
            if (idx < base) return 1'b0;
            return hd[idx % HN];
        endfunction
        function automatic logic smp_a(input int idx);
            if (idx < base) return 1'b0;
            return ha[idx % HN];
        endfunction

        always @(posedge clk or negedge rst_n) begin : p_model
            logic [15:0] bev;
            logic        uev, dev, any_ev, tick_ev, mode_new;
            int          nl;
            if (!rst_n) begin
                m_lvl  = 0;
                m_chg  = 1'b0;
                m_mode = 1'b0;
                base   = n + 1;
                r_last = n;
            end else begin
                n = n + 1;
                hb[n % HN] = 16'(w_btn);
                hu[n % HN] = m_up;
                hd[n % HN] = m_down;
                ha[n % HN] = m_auto;
                bev      = smp_b(n - SS) & ~smp_b(n - SS - 1);
                uev      = smp_u(n - SS) & ~smp_u(n - SS - 1);
                dev      = smp_d(n - SS) & ~smp_d(n - SS - 1);
                mode_new = smp_a(n - SS + 1);
                any_ev   = (bev != 0) || uev || dev;
                tick_ev  = m_mode && (n > r_last) && (((n - r_last) % AP) == 0);
                nl = m_lvl;
                if (bev != 0) begin
                    for (int k = 15; k >= 0; k--) if (bev[k]) nl = k;
                end else if (uev != dev) begin
                    if (uev) nl = (m_lvl == LV-1) ? ((WR != 0) ? 0 : m_lvl) : m_lvl + 1;
                    else     nl = (m_lvl == 0) ? ((WR != 0) ? LV-1 : 0) : m_lvl - 1;
                end else if (tick_ev) begin
                    nl = (m_lvl + 1) % LV;
                end
                if ((mode_new != m_mode) || any_ev) r_last = n;
                m_chg  = (nl != m_lvl);
                m_lvl  = nl;
                m_mode = mode_new;
            end
        end

        always @(negedge clk) begin
            chk_eq($sformatf("c%0d level", g),   32'(w_lvl), 32'(m_lvl));
            chk_eq($sformatf("c%0d onehot", g),  32'(w_oh),  32'(1) << m_lvl);
            chk_eq($sformatf("c%0d changed", g), 32'(w_chg), 32'(m_chg));
            chk_eq($sformatf("c%0d auto", g),    32'(w_act), 32'(m_mode));
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [15:0] b, input logic u, input logic d);
        m_btn = b; m_up = u; m_down = d;
        tick(1);
        m_btn = '0; m_up = 1'b0; m_down = 1'b0;
        tick(2);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(1);
        m_btn = 16'h001f;
        tick(1);
        m_btn = 16'h000a; m_up = 1'b1;
        tick(1);
        m_up = 1'b0;
        chk_eq("rst level",   32'(g_cfg[0].w_lvl), 0);
        chk_eq("rst onehot",  32'(g_cfg[0].w_oh),  32'h1);
        chk_eq("rst changed", 32'(g_cfg[0].w_chg), 0);
        chk_eq("rst auto",    32'(g_cfg[0].w_act), 0);

        // Button 3 held through reset release.
        m_btn = 16'h0008;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk_eq("held pre level", 32'(g_cfg[0].w_lvl), 0);
        tick(1);
        chk_eq("held level",   32'(g_cfg[0].w_lvl), 3);
        chk_eq("held onehot",  32'(g_cfg[0].w_oh),  32'h8);
        chk_eq("held changed", 32'(g_cfg[0].w_chg), 1);
        tick(1);
        chk_eq("held strobe end", 32'(g_cfg[0].w_chg), 0);
        tick(5);
        chk_eq("held stays", 32'(g_cfg[0].w_lvl), 3);
        m_btn = '0;
        tick(3);

        pulse(16'h0014, 1'b0, 1'b0);
        chk_eq("prio level",   32'(g_cfg[0].w_lvl), 2);
        chk_eq("prio changed", 32'(g_cfg[0].w_chg), 1);
        tick(2);
        pulse(16'h0004, 1'b0, 1'b0);
        chk_eq("resel level",   32'(g_cfg[0].w_lvl), 2);
        chk_eq("resel changed", 32'(g_cfg[0].w_chg), 0);
        tick(1);

        pulse(16'h0010, 1'b0, 1'b0);
        chk_eq("sel4 level", 32'(g_cfg[0].w_lvl), 4);
        tick(1);
        pulse(16'h0000, 1'b1, 1'b0);
        chk_eq("up wrap level",   32'(g_cfg[0].w_lvl), 0);
        chk_eq("up wrap changed", 32'(g_cfg[0].w_chg), 1);
        chk_eq("up sat level",    32'(g_cfg[1].w_lvl), 4);
        chk_eq("up sat changed",  32'(g_cfg[1].w_chg), 0);
        tick(1);
        pulse(16'h0000, 1'b0, 1'b1);
        chk_eq("down wrap level", 32'(g_cfg[0].w_lvl), 4);
        chk_eq("down sat cfg",    32'(g_cfg[1].w_lvl), 3);
        tick(1);
        pulse(16'h0000, 1'b1, 1'b1);
        chk_eq("updown level",   32'(g_cfg[0].w_lvl), 4);
        chk_eq("updown changed", 32'(g_cfg[0].w_chg), 0);
        tick(1);

        pulse(16'h0001, 1'b0, 1'b0);
        tick(1);
        m_auto = 1'b1;
        tick(2);
        chk_eq("auto active", 32'(g_cfg[0].w_act), 1);
        chk_eq("auto start",  32'(g_cfg[0].w_lvl), 0);
        for (int j = 1; j <= 5; j++) begin
            tick(7);
            chk_eq("auto hold", 32'(g_cfg[0].w_lvl), 32'((j - 1) % 5));
            tick(1);
            chk_eq("auto step",   32'(g_cfg[0].w_lvl), 32'(j % 5));
            chk_eq("auto strobe", 32'(g_cfg[0].w_chg), 1);
        end
        tick(3);
        pulse(16'h0002, 1'b0, 1'b0);
        chk_eq("auto btn", 32'(g_cfg[0].w_lvl), 1);
        tick(7);
        chk_eq("auto restart hold", 32'(g_cfg[0].w_lvl), 1);
        tick(1);
        chk_eq("auto restart step", 32'(g_cfg[0].w_lvl), 2);

        m_auto = 1'b0;
        tick(2);
        chk_eq("auto exit", 32'(g_cfg[0].w_act), 0);
        tick(20);
        chk_eq("manual hold", 32'(g_cfg[0].w_lvl), 2);

        m_auto = 1'b1;
        tick(6);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("arst level",   32'(g_cfg[0].w_lvl), 0);
        chk_eq("arst onehot",  32'(g_cfg[0].w_oh),  32'h1);
        chk_eq("arst changed", 32'(g_cfg[0].w_chg), 0);
        chk_eq("arst auto",    32'(g_cfg[0].w_act), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk_eq("rearm auto", 32'(g_cfg[0].w_act), 1);
        tick(7);
        chk_eq("rearm hold", 32'(g_cfg[0].w_lvl), 0);
        tick(1);
        chk_eq("rearm step", 32'(g_cfg[0].w_lvl), 1);
        m_auto = 1'b0;
        tick(3);

        for (int k = 0; k < 16; k++) begin
            pulse(16'(1) << k, 1'b0, 1'b0);
            chk_eq("sweep16 level",  32'(g_cfg[3].w_lvl), 32'(k));
            chk_eq("sweep16 onehot", 32'(g_cfg[3].w_oh),  32'(1) << k);
            if (k < 2) begin
                chk_eq("sweep2 level",  32'(g_cfg[2].w_lvl), 32'(k));
                chk_eq("sweep2 onehot", 32'(g_cfg[2].w_oh),  32'(1) << k);
            end
            tick(1);
        end
        pulse(16'h0000, 1'b1, 1'b0);
        chk_eq("wrap16 up",  32'(g_cfg[3].w_oh), 32'h0001);
        chk_eq("wrap2 up",   32'(g_cfg[2].w_oh), 32'h1);
        tick(1);
        pulse(16'h0000, 1'b0, 1'b1);
        chk_eq("wrap16 down", 32'(g_cfg[3].w_lvl), 15);
        chk_eq("wrap16 oh",   32'(g_cfg[3].w_oh),  32'h8000);
        chk_eq("wrap2 down",  32'(g_cfg[2].w_lvl), 1);
        chk_eq("wrap2 oh",    32'(g_cfg[2].w_oh),  32'h2);
        tick(1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) m_btn = m_btn ^ (16'(1) << $urandom_range(0, 15));
            m_up   = ($urandom_range(0, 39) == 0);
            m_down = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) m_auto = ~m_auto;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
